// File: rtl/vga_scan_controller_pkg.sv
// Shared constants for the debug-display scan controller: default VGA 640x480@60 timing,
// snapshot field widths and the snapshot FSM state type.
package vga_scan_controller_pkg;

    localparam int unsigned COORD_W    = 11;
    localparam int unsigned REG_HEAP_W = 176;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned COLOR_W    = 3;

    localparam int unsigned DEF_CLK_DIV  = 2;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;

    typedef enum logic [0:0] {
        StScan,
        StCapture
    } snapState_e;

    // True when val lies in the half-open window [lo, lo + len).
    function automatic logic inWindow(logic [COORD_W-1:0] val, int unsigned lo, int unsigned len);
        return (val >= COORD_W'(lo)) && (val < COORD_W'(lo + len));
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-enable divider and raster counters with visible-area, sync and end-of-visible decode.
module vga_timing_counter
    import vga_scan_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pe,
    output logic [COORD_W-1:0] hCount,
    output logic [COORD_W-1:0] vCount,
    output logic               visible,
    output logic               hSyncN,
    output logic               vSyncN,
    output logic               frameEnd
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_VIS_LAST = COORD_W'(V_ACTIVE - 1);

    logic [DIV_W-1:0]   divCntQ, divCntD;
    logic [COORD_W-1:0] hCountQ, hCountD;
    logic [COORD_W-1:0] vCountQ, vCountD;

    // With CLK_DIV == 1 the divider never leaves 0, so pe is constantly high.
    assign pe = (divCntQ == DIV_LAST);

    // Next-state for the divider and the raster counters; scan moves only on pe.
    always_comb begin
        divCntD = divCntQ + DIV_W'(1);
        hCountD = hCountQ;
        vCountD = vCountQ;
        if (pe) begin
            divCntD = '0;
            if (hCountQ == H_LAST) begin
                hCountD = '0;
                vCountD = (vCountQ == V_LAST) ? '0 : vCountQ + COORD_W'(1);
            end else begin
                hCountD = hCountQ + COORD_W'(1);
            end
        end
    end

    // Counter registers; a reset mid-frame restarts the scan at (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCntQ <= '0;
            hCountQ <= '0;
            vCountQ <= '0;
        end else begin
            divCntQ <= divCntD;
            hCountQ <= hCountD;
            vCountQ <= vCountD;
        end
    end

    assign hCount   = hCountQ;
    assign vCount   = vCountQ;
    assign visible  = (hCountQ < COORD_W'(H_ACTIVE)) && (vCountQ < COORD_W'(V_ACTIVE));
    assign hSyncN   = !inWindow(hCountQ, H_ACTIVE + H_FP, H_SYNC);
    assign vSyncN   = !inWindow(vCountQ, V_ACTIVE + V_FP, V_SYNC);
    // Last pixel of the last visible line is being left on this clock.
    assign frameEnd = pe && (hCountQ == H_LAST) && (vCountQ == V_VIS_LAST);

endmodule

// File: rtl/vga_scan_controller.sv
// Debug-display scan controller: drives x/y to the renderer, registers its colour together
// with sync, and snapshots CPU debug state once per frame at the start of vertical blanking.
module vga_scan_controller
    import vga_scan_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic [REG_HEAP_W-1:0] registerValueIn,
    input  logic [WORD_W-1:0]     IfPCIn,
    input  logic [WORD_W-1:0]     IfIRIn,
    input  logic [WORD_W-1:0]     calResultIn,
    output logic [REG_HEAP_W-1:0] registerValue,
    output logic [WORD_W-1:0]     IfPC,
    output logic [WORD_W-1:0]     IfIR,
    output logic [WORD_W-1:0]     calResult,
    output logic [COORD_W-1:0]    x,
    output logic [COORD_W-1:0]    y,
    input  logic [COLOR_W-1:0]    rIn,
    input  logic [COLOR_W-1:0]    gIn,
    input  logic [COLOR_W-1:0]    bIn,
    output logic [COLOR_W-1:0]    r,
    output logic [COLOR_W-1:0]    g,
    output logic [COLOR_W-1:0]    b,
    output logic                  hs,
    output logic                  vs,
    output logic                  frameStart
);

    logic       pe;
    logic       visible;
    logic       hSyncN;
    logic       vSyncN;
    logic       frameEnd;
    logic       captureEn;
    snapState_e stateQ, stateD;

    vga_timing_counter #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) uTiming (
        .clk      (clk),
        .rst      (rst),
        .pe       (pe),
        .hCount   (x),
        .vCount   (y),
        .visible  (visible),
        .hSyncN   (hSyncN),
        .vSyncN   (vSyncN),
        .frameEnd (frameEnd)
    );

    // Output stage: colour and sync for the current pixel leave together one pixel later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r  <= '0;
            g  <= '0;
            b  <= '0;
            hs <= 1'b1;
            vs <= 1'b1;
        end else if (pe) begin
            r  <= visible ? rIn : '0;
            g  <= visible ? gIn : '0;
            b  <= visible ? bIn : '0;
            hs <= hSyncN;
            vs <= vSyncN;
        end
    end

    // Snapshot FSM next state: one CAPTURE clock right after the last visible pixel.
    always_comb begin
        stateD    = stateQ;
        captureEn = 1'b0;
        unique case (stateQ)
            StScan: begin
                if (frameEnd) begin
                    stateD = StCapture;
                end
            end
            StCapture: begin
                stateD    = StScan;
                captureEn = !freeze;
            end
            default: stateD = StScan;
        endcase
    end

    // Snapshot FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StScan;
        end else begin
            stateQ <= stateD;
        end
    end

    // Snapshot registers; frameStart rises in the same clock the new snapshot appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            registerValue <= '0;
            IfPC          <= '0;
            IfIR          <= '0;
            calResult     <= '0;
            frameStart    <= 1'b0;
        end else begin
            frameStart <= captureEn;
            if (captureEn) begin
                registerValue <= registerValueIn;
                IfPC          <= IfPCIn;
                IfIR          <= IfIRIn;
                calResult     <= calResultIn;
            end
        end
    end

endmodule
